// File: rtl/pixel_word_unpacker_if.sv
// Pixel-word bus between the memory side and the sharpening datapath.
// Word side: in_valid/in_ready handshake carrying in_data (two packed pixels) and in_last.
// Pixel side: pix_valid/pix_ready handshake carrying pix_data and pix_last.
// word_count reports the number of words currently buffered by the unpacker.
// master: the surrounding environment (drives words in, accepts pixels out).
// slave:  the unpacker itself.
interface pixel_word_unpacker_if #(
  parameter int unsigned CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             pix_valid;
  logic             pix_ready;
  logic [7:0]       pix_data;
  logic             pix_last;
  logic [CNT_W-1:0] word_count;

  modport master (
    output in_valid, in_data, in_last, pix_ready,
    input  in_ready, pix_valid, pix_data, pix_last, word_count
  );

  modport slave (
    input  in_valid, in_data, in_last, pix_ready,
    output in_ready, pix_valid, pix_data, pix_last, word_count
  );
endinterface

// File: rtl/pixel_word_unpacker.sv
// Receive end of the 16-bit pixel-word bus. Buffers packed words (two 8-bit pixels each)
// in a small first-word-fall-through FIFO and emits one pixel per cycle.
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_clear  - synchronous flush (empties FIFO, resets byte select), highest priority
//   bus      - pixel_word_unpacker_if.slave: word input handshake, pixel output handshake,
//              and word_count (0..DEPTH)
// Optional build macro PIXEL_UNPACK_MSB_FIRST_EN: emit in_data[15:8] first, then [7:0].
module pixel_word_unpacker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  input logic                   i_clear,
  pixel_word_unpacker_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Each entry is {last, data}
  logic [16:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_sel;

  logic             w_in_ready;
  logic             w_pix_valid;
  logic             w_push;
  logic             w_pix_hs;
  logic             w_pop;
  logic [16:0]      w_head;
  logic [CNT_W-1:0] w_count_nxt;

  // Ready depends only on state, so there is no combinational path from pix_ready.
  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_pix_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready && !i_clear;
  assign w_pix_hs    = w_pix_valid && bus.pix_ready && !i_clear;
  // A word leaves the FIFO only once its second pixel is taken.
  assign w_pop       = w_pix_hs && r_sel;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sel    <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sel    <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_pix_hs) r_sel <= ~r_sel;
      r_count <= w_count_nxt;
    end
  end

  // Storage needs no reset; contents are only observed when the count says they are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_last, bus.in_data};
  end

  always_comb begin
`ifdef PIXEL_UNPACK_MSB_FIRST_EN
    bus.pix_data = r_sel ? w_head[7:0] : w_head[15:8];
`else
    bus.pix_data = r_sel ? w_head[15:8] : w_head[7:0];
`endif
    bus.pix_last   = w_head[16] && r_sel && w_pix_valid;
    bus.pix_valid  = w_pix_valid;
    bus.in_ready   = w_in_ready;
    bus.word_count = r_count;
  end

endmodule

// File: doc/pixel_word_unpacker.md
Name: pixel_word_unpacker

Overview:
- Receive end of the 16-bit pixel-word bus between the DLX memory side and the image-sharpening datapath.
- Accepts packed words, each holding two 8-bit pixels, through a valid/ready handshake.
- Buffers words in a small FIFO and emits one pixel per cycle to the sharpening kernel, with backpressure on both sides.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words; power of two, minimum 2.
- CNT_W, 3, width of WORD_COUNT; must equal log2(DEPTH)+1.

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RESET_N  input  1  asynchronous active-low reset.
- CLEAR  input  1  synchronous flush; empties FIFO, resets byte select.
- IN_VALID  input  1  IN_DATA/IN_LAST valid.
- IN_READY  output  1  word accepted at edge when IN_VALID && IN_READY.
- IN_DATA  input  16  packed pixels; [7:0] is pixel 0, [15:8] is pixel 1.
- IN_LAST  input  1  word is the last of an image line.
- PIX_VALID  output  1  PIX_DATA/PIX_LAST valid.
- PIX_READY  input  1  downstream accepts pixel at edge when PIX_VALID && PIX_READY.
- PIX_DATA  output  8  current pixel.
- PIX_LAST  output  1  current pixel is the final pixel of a line.
- WORD_COUNT  output  CNT_W  words held in FIFO, 0..DEPTH.

Behaviour:
- One clock, CLK. Reset is asynchronous, active-low on RESET_N.
- Reset values: write/read pointers 0, WORD_COUNT 0, byte select SEL 0, PIX_VALID 0, IN_READY 1, PIX_LAST 0.
- PIX_DATA is don't-care under reset and while PIX_VALID is 0; the bench checks it only when valid.
- Storage: DEPTH entries of {IN_LAST, IN_DATA}. Circular pointers wrap from DEPTH-1 to 0.
- IN_READY = (WORD_COUNT != DEPTH).
  - Registered/state-derived only; no combinational path from PIX_READY.
  - When full, a same-cycle pop does not enable a push.
- Push: IN_VALID && IN_READY stores the word at the write pointer and increments it.
- Output is first-word-fall-through:
  - PIX_VALID = (WORD_COUNT != 0).
  - PIX_DATA = head[7:0] when SEL=0, head[15:8] when SEL=1.
  - PIX_LAST = head.last && SEL.
- Latency: a word pushed at edge N has pixel 0 visible in the cycle after edge N, if the FIFO was empty.
- Pixel handshake on PIX_VALID && PIX_READY:
  - SEL=0: SEL becomes 1; no pop.
  - SEL=1: SEL becomes 0; head popped, read pointer incremented.
- Output holds stable while PIX_VALID && !PIX_READY (no change of PIX_DATA or PIX_LAST).
- Simultaneous push and pop: WORD_COUNT unchanged; both pointers advance.
  - Push into an empty FIFO with no pop: count 0 to 1.
- WORD_COUNT: +1 on push only, -1 on pop only, otherwise unchanged.
- Sustained rate: 1 pixel/cycle out, i.e. 1 word per 2 cycles in; input stalls are expected at full.
- CLEAR (synchronous, highest priority):
  - Pointers, count and SEL go to 0.
  - A push or pixel handshake in the same cycle is ignored.
  - Next cycle: PIX_VALID=0, IN_READY=1.
- Reset mid-operation: all state returns immediately to reset values; buffered words are discarded.

Optional Feature:
- Macro PIXEL_UNPACK_MSB_FIRST_EN.
- Defined: pixel order swapped.
  - SEL=0 emits IN_DATA[15:8], SEL=1 emits IN_DATA[7:0].
  - PIX_LAST still asserts on the second pixel of a last word.
- Undefined: low byte first, as described above.
- No port or timing difference.

Test Plan:
- Reset and idle: RESET_N low, then high, with no stimulus -> PIX_VALID=0, IN_READY=1, WORD_COUNT=0.
- Single word: push 16'hB2A1 with IN_LAST=1, PIX_READY=1 -> pixels 8'hA1 (PIX_LAST=0) then 8'hB2 (PIX_LAST=1) on consecutive cycles, then PIX_VALID=0, WORD_COUNT back to 0.
- Fill and backpressure:
  - PIX_READY=0; push 16'h0100, 16'h0302, 16'h0504, 16'h0706 -> WORD_COUNT=4, IN_READY=0.
  - A fifth word held on the bus is not accepted.
  - Raise PIX_READY -> pixels 00..07 in order.
  - IN_READY rises the cycle after the first pop.
- Stall mid-word: push 16'h2211, accept 8'h11, then hold PIX_READY=0 for 3 cycles -> PIX_DATA stays 8'h22, PIX_VALID=1; then accepted.
- Streaming with wrap-around: push 10 words 16'h0100 + k*16'h0202 at the maximum accepted rate with PIX_READY=1 -> 20 pixels 00..13 hex in order, no loss or duplication, WORD_COUNT never exceeds 4.
- CLEAR and option:
  - 3 words buffered, CLEAR pulsed with a concurrent push -> next cycle WORD_COUNT=0, PIX_VALID=0, pushed word dropped.
  - With PIXEL_UNPACK_MSB_FIRST_EN, word 16'hB2A1 -> 8'hB2 then 8'hA1.
